// File: rtl/kiss_stream_gen_pkg.sv
// -----------------------------------------------------------------------------
// kiss_stream_gen_pkg
// Shared types and constants for the KISS stream generator:
//   - kiss_state_t : packed per-lane generator state {jcong, jsr, w, z}
//   - SEED_*       : power-on seeds loaded into every lane on reset
//   - SEL_*        : seed_sel encodings for the seed-word write port
//   - kiss_fsm_e   : two-state controller encoding (IDLE / RUN)
//   - lane_reset_state() : reset state of a given lane (jcong is offset
//                          by the lane index so lanes diverge)
// -----------------------------------------------------------------------------
package kiss_stream_gen_pkg;

    // First member is the most significant, so the packed value reads
    // {jcong, jsr, w, z} when viewed as a 128-bit vector.
    typedef struct packed {
        logic [31:0] jcong;
        logic [31:0] jsr;
        logic [31:0] w;
        logic [31:0] z;
    } kiss_state_t;

    localparam logic [31:0] SEED_Z     = 32'd362436069;
    localparam logic [31:0] SEED_W     = 32'd521288629;
    localparam logic [31:0] SEED_JSR   = 32'd123456789;
    localparam logic [31:0] SEED_JCONG = 32'd380116160;

    localparam logic [1:0] SEL_Z     = 2'd0;
    localparam logic [1:0] SEL_W     = 2'd1;
    localparam logic [1:0] SEL_JSR   = 2'd2;
    localparam logic [1:0] SEL_JCONG = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        FSM_IDLE = ST_IDLE,
        FSM_RUN  = ST_RUN
    } kiss_fsm_e;

    function automatic kiss_state_t lane_reset_state(input int unsigned lane);
        kiss_state_t s;
        s.z     = SEED_Z;
        s.w     = SEED_W;
        s.jsr   = SEED_JSR;
        s.jcong = SEED_JCONG + 32'(lane);
        return s;
    endfunction

endpackage

// File: rtl/kiss_stream_gen_step.sv
// -----------------------------------------------------------------------------
// kiss_step
// Purely combinational single step of Marsaglia's KISS generator.
// Ports:
//   cur : current lane state
//   nxt : lane state after one step
//   rnd : output word A = (MWC ^ jcong) + jsr computed from the new state
// All arithmetic is unsigned 32-bit and wraps naturally.
// -----------------------------------------------------------------------------
module kiss_step
    import kiss_stream_gen_pkg::*;
(
    input  kiss_state_t cur,
    output kiss_state_t nxt,
    output logic [31:0] rnd
);

    logic [31:0] z_n;
    logic [31:0] w_n;
    logic [31:0] jsr_a;
    logic [31:0] jsr_b;
    logic [31:0] jsr_n;
    logic [31:0] jcong_n;
    logic [31:0] mwc;

    always_comb begin
        // Two multiply-with-carry halves: low 16 bits times the multiplier,
        // high 16 bits act as the carry.
        z_n = 32'd36969 * {16'd0, cur.z[15:0]} + {16'd0, cur.z[31:16]};
        w_n = 32'd18000 * {16'd0, cur.w[15:0]} + {16'd0, cur.w[31:16]};
        mwc = (z_n << 16) + w_n;

        // 3-shift xorshift register, applied in sequence.
        jsr_a = cur.jsr ^ (cur.jsr << 17);
        jsr_b = jsr_a ^ (jsr_a >> 13);
        jsr_n = jsr_b ^ (jsr_b << 5);

        jcong_n = 32'd69069 * cur.jcong + 32'd1234567;

        nxt.z     = z_n;
        nxt.w     = w_n;
        nxt.jsr   = jsr_n;
        nxt.jcong = jcong_n;
        rnd       = (mwc ^ jcong_n) + jsr_n;
    end

endmodule

// File: rtl/kiss_stream_gen.sv
// -----------------------------------------------------------------------------
// kiss_stream_gen
// Multi-lane KISS random stream generator with a valid/ready output.
// A start request with a non-zero length produces that many beats, each beat
// carrying one fresh 32-bit word per lane. Lane state persists across runs.
//
// Parameters:
//   LANES  : number of independent generators (1..8)
//   LEN_W  : width of the beat-count request
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   seed_we/lane/sel/data : write one state word of one lane (IDLE only)
//   start, length       : request a run of `length` beats
//   busy                : high while a run is in progress
//   done                : one-cycle pulse when a run ends (or length==0)
//   out_valid/ready     : output handshake
//   out_data            : lane i in bits [32i+31:32i]
//   out_last            : current beat is the last of the run
// Optional (macro KISS_STATE_READBACK_EN):
//   rd_lane, rd_state   : combinational view {jcong,jsr,w,z} of one lane
// -----------------------------------------------------------------------------
module kiss_stream_gen
    import kiss_stream_gen_pkg::*;
#(
    parameter  int LANES  = 4,
    parameter  int LEN_W  = 16,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_we,
    input  logic [LANE_W-1:0]     seed_lane,
    input  logic [1:0]            seed_sel,
    input  logic [31:0]           seed_data,
    input  logic                  start,
    input  logic [LEN_W-1:0]      length,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data,
    output logic                  out_last
`ifdef KISS_STATE_READBACK_EN
    ,
    input  logic [LANE_W-1:0]     rd_lane,
    output logic [127:0]          rd_state
`endif
);

    kiss_fsm_e        state;
    logic [LEN_W-1:0] remaining;
    logic             idle;

    kiss_state_t lane_q      [LANES];
    kiss_state_t lane_seeded [LANES];
    kiss_state_t lane_next   [LANES];
    logic [31:0] lane_rnd    [LANES];

    assign idle = (state == FSM_IDLE);

    // The seed write is merged in front of the step logic so that a write
    // coinciding with start is already visible to the first step.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_seeded[i] = lane_q[i];
            if (idle && seed_we && (seed_lane == LANE_W'(i))) begin
                case (seed_sel)
                    SEL_Z:     lane_seeded[i].z     = seed_data;
                    SEL_W:     lane_seeded[i].w     = seed_data;
                    SEL_JSR:   lane_seeded[i].jsr   = seed_data;
                    SEL_JCONG: lane_seeded[i].jcong = seed_data;
                endcase
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        kiss_step u_step (
            .cur (lane_seeded[g]),
            .nxt (lane_next[g]),
            .rnd (lane_rnd[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FSM_IDLE;
            remaining <= '0;
            done      <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_reset_state(i);
            end
        end else begin
            done <= 1'b0;
            case (state)
                FSM_IDLE: begin
                    for (int i = 0; i < LANES; i++) begin
                        lane_q[i] <= lane_seeded[i];
                    end
                    if (start) begin
                        if (length != '0) begin
                            for (int i = 0; i < LANES; i++) begin
                                lane_q[i]            <= lane_next[i];
                                out_data[32*i +: 32] <= lane_rnd[i];
                            end
                            remaining <= length;
                            state     <= FSM_RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FSM_RUN: begin
                    if (out_ready) begin
                        // The final acceptance ends the run without stepping,
                        // so the next run continues exactly where this left off.
                        if (remaining > LEN_W'(1)) begin
                            for (int i = 0; i < LANES; i++) begin
                                lane_q[i]            <= lane_next[i];
                                out_data[32*i +: 32] <= lane_rnd[i];
                            end
                            remaining <= remaining - LEN_W'(1);
                        end else begin
                            remaining <= '0;
                            done      <= 1'b1;
                            state     <= FSM_IDLE;
                        end
                    end
                end
                default: state <= FSM_IDLE;
            endcase
        end
    end

    assign busy      = (state == FSM_RUN);
    assign out_valid = busy;
    assign out_last  = busy && (remaining == LEN_W'(1));

`ifdef KISS_STATE_READBACK_EN
    assign rd_state = lane_q[rd_lane];
`endif

endmodule

// File: tb/tb_kiss_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_kiss_stream_gen
// Directed self-checking bench for kiss_stream_gen. A 4-lane instance covers
// seeding, handshaking, zero-length, ignored requests and mid-run reset;
// 1-lane and 8-lane instances cover split runs against a continuous model.
// Readback checks are compiled in when KISS_STATE_READBACK_EN is defined.
// -----------------------------------------------------------------------------
module tb_kiss_stream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         seed_we = 1'b0;
    logic [1:0]   seed_lane = '0;
    logic [1:0]   seed_sel = '0;
    logic [31:0]  seed_data = '0;
    logic         start = 1'b0;
    logic [15:0]  length = '0;
    logic         out_ready = 1'b0;
    logic         busy, done, out_valid, out_last;
    logic [127:0] out_data;

    logic         start_x = 1'b0;
    logic [15:0]  length_x = '0;
    logic         out_ready_x = 1'b0;
    logic         tie_we = 1'b0;
    logic [1:0]   tie_sel = '0;
    logic [31:0]  tie_data = '0;
    logic [0:0]   tie_lane1 = '0;
    logic [2:0]   tie_lane8 = '0;
    logic         busy1, done1, valid1, last1;
    logic [31:0]  data1;
    logic         busy8, done8, valid8, last8;
    logic [255:0] data8;

`ifdef KISS_STATE_READBACK_EN
    logic [1:0]   rd_lane = '0;
    logic [127:0] rd_state;
    logic [0:0]   rd_lane1 = '0;
    logic [127:0] rd_state1;
    logic [2:0]   rd_lane8 = '0;
    logic [127:0] rd_state8;
`endif

    kiss_stream_gen #(.LANES(4), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .seed_we(seed_we), .seed_lane(seed_lane),
        .seed_sel(seed_sel), .seed_data(seed_data), .start(start), .length(length),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
`ifdef KISS_STATE_READBACK_EN
        , .rd_lane(rd_lane), .rd_state(rd_state)
`endif
    );

    kiss_stream_gen #(.LANES(1), .LEN_W(16)) dut1 (
        .clk(clk), .rst(rst), .seed_we(tie_we), .seed_lane(tie_lane1),
        .seed_sel(tie_sel), .seed_data(tie_data), .start(start_x), .length(length_x),
        .busy(busy1), .done(done1), .out_valid(valid1), .out_ready(out_ready_x),
        .out_data(data1), .out_last(last1)
`ifdef KISS_STATE_READBACK_EN
        , .rd_lane(rd_lane1), .rd_state(rd_state1)
`endif
    );

    kiss_stream_gen #(.LANES(8), .LEN_W(16)) dut8 (
        .clk(clk), .rst(rst), .seed_we(tie_we), .seed_lane(tie_lane8),
        .seed_sel(tie_sel), .seed_data(tie_data), .start(start_x), .length(length_x),
        .busy(busy8), .done(done8), .out_valid(valid8), .out_ready(out_ready_x),
        .out_data(data8), .out_last(last8)
`ifdef KISS_STATE_READBACK_EN
        , .rd_lane(rd_lane8), .rd_state(rd_state8)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [127:0] m4 [4];
    logic [127:0] m8 [8];
    logic [127:0] m1;

    // Reference step: returns {A, jcong, jsr, w, z}.
    function automatic logic [159:0] kiss_next(input logic [127:0] s);
        logic [31:0] z, w, j, c, mwc;
        z = s[31:0];
        w = s[63:32];
        j = s[95:64];
        c = s[127:96];
        z = 32'd36969 * (z & 32'h0000FFFF) + (z >> 16);
        w = 32'd18000 * (w & 32'h0000FFFF) + (w >> 16);
        mwc = (z << 16) + w;
        j = j ^ (j << 17);
        j = j ^ (j >> 13);
        j = j ^ (j << 5);
        c = 32'd69069 * c + 32'd1234567;
        return {(mwc ^ c) + j, c, j, w, z};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m8[i] = {32'd380116160 + 32'(i), 32'd123456789, 32'd521288629, 32'd362436069};
        end
        for (int i = 0; i < 4; i++) m4[i] = m8[i];
        m1 = m8[0];
    endtask

    task automatic adv4(output logic [127:0] beat);
        logic [159:0] r;
        for (int i = 0; i < 4; i++) begin
            r = kiss_next(m4[i]);
            m4[i] = r[127:0];
            beat[32*i +: 32] = r[159:128];
        end
    endtask

    task automatic adv8(output logic [255:0] beat);
        logic [159:0] r;
        for (int i = 0; i < 8; i++) begin
            r = kiss_next(m8[i]);
            m8[i] = r[127:0];
            beat[32*i +: 32] = r[159:128];
        end
    endtask

    task automatic adv1(output logic [31:0] beat);
        logic [159:0] r;
        r = kiss_next(m1);
        m1 = r[127:0];
        beat = r[159:128];
    endtask

    task automatic seed_write(input logic [1:0] lane, input logic [1:0] sel, input logic [31:0] data);
        seed_we   = 1'b1;
        seed_lane = lane;
        seed_sel  = sel;
        seed_data = data;
        @(negedge clk);
        seed_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b want=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_last got=%0b want=0", out_last); end
        checks++; if (out_data !== 128'd0) begin failures++; $display("[TB] FAIL reset_data got=%h want=0", out_data); end
        checks++; if (data8 !== 256'd0 || valid8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_dut8 got data=%h valid=%0b want 0", data8, valid8); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_beat();
        logic [127:0] e;
        seed_write(2'd0, 2'd0, 32'd1);
        seed_write(2'd0, 2'd1, 32'd1);
        seed_write(2'd0, 2'd2, 32'd1);
        seed_write(2'd0, 2'd3, 32'd0);
        m4[0] = {32'd0, 32'd1, 32'd1, 32'd1};
        start = 1'b1; length = 16'd1;
        @(negedge clk);
        start = 1'b0;
        adv4(e);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%0b want=1", out_valid); end
        checks++; if (out_last !== 1'b1) begin failures++; $display("[TB] FAIL single_last got=%0b want=1", out_last); end
        checks++; if (out_data[31:0] !== 32'h90BD9308) begin failures++; $display("[TB] FAIL single_lane0 got=%h want=90bd9308", out_data[31:0]); end
        checks++; if (out_data !== e) begin failures++; $display("[TB] FAIL single_all_lanes got=%h want=%h", out_data, e); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL single_done got=%0b want=1", done); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_drop got=%0b want=0", out_valid); end
`ifdef KISS_STATE_READBACK_EN
        rd_lane = 2'd0;
        #1;
        checks++; if (rd_state !== {32'h0012D687, 32'h00420231, 32'h00004650, 32'h00009069}) begin
            failures++; $display("[TB] FAIL single_readback got=%h want=0012d687_00420231_00004650_00009069", rd_state); end
`endif
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL single_done_width got=%0b want=0", done); end
    endtask

    task automatic test_backpressure();
        logic [127:0] e [5];
        int beats = 0, hold = 0, dones = 0;
        for (int k = 0; k < 5; k++) adv4(e[k]);
        start = 1'b1; length = 16'd5;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (done === 1'b1) dones++;
            if (out_valid === 1'b1) begin
                if (beats < 5) begin
                    checks++; if (out_data !== e[beats]) begin failures++; $display("[TB] FAIL bp_beat%0d got=%h want=%h", beats, out_data, e[beats]); end
                    checks++; if (out_last !== (beats == 4)) begin failures++; $display("[TB] FAIL bp_last%0d got=%0b want=%0b", beats, out_last, beats == 4); end
                end
                if (beats == 1 && hold < 3) begin
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    out_ready = 1'b1;
                    beats++;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (beats != 5) begin failures++; $display("[TB] FAIL bp_beat_count got=%0d want=5", beats); end
        checks++; if (dones != 1) begin failures++; $display("[TB] FAIL bp_done_count got=%0d want=1", dones); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle_after got=%0b want=0", busy); end
    endtask

    task automatic test_zero_length();
        start = 1'b1; length = 16'd0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL zero_done got=%0b want=1", done); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL zero_idle got valid=%0b busy=%0b want 0", out_valid, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL zero_after got done=%0b valid=%0b want 0", done, out_valid); end
    endtask

    task automatic test_ignore_in_run();
        logic [127:0] e [3];
        for (int k = 0; k < 3; k++) adv4(e[k]);
        start = 1'b1; length = 16'd3;
        @(negedge clk);
        start = 1'b0;
        checks++; if (out_data !== e[0]) begin failures++; $display("[TB] FAIL ign_beat0 got=%h want=%h", out_data, e[0]); end
        seed_we = 1'b1; seed_lane = 2'd0; seed_sel = 2'd0; seed_data = 32'hDEADBEEF;
        start = 1'b1; length = 16'd7;
        @(negedge clk);
        seed_we = 1'b0; start = 1'b0;
        checks++; if (out_data !== e[0] || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL ign_hold got=%h valid=%0b want=%h valid=1", out_data, out_valid, e[0]); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_data !== e[1]) begin failures++; $display("[TB] FAIL ign_beat1 got=%h want=%h", out_data, e[1]); end
        @(negedge clk);
        checks++; if (out_data !== e[2] || out_last !== 1'b1) begin failures++; $display("[TB] FAIL ign_beat2 got=%h last=%0b want=%h last=1", out_data, out_last, e[2]); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ign_end got done=%0b valid=%0b want done=1 valid=0", done, out_valid); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ign_no_restart got busy=%0b want=0", busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] e [3];
        logic [127:0] f;
        for (int k = 0; k < 3; k++) adv4(e[k]);
        out_ready = 1'b1;
        start = 1'b1; length = 16'd8;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_data !== e[k]) begin failures++; $display("[TB] FAIL rst_run_beat%0d got=%h want=%h", k, out_data, e[k]); end
            if (k == 2) rst = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_run_ctrl got valid=%0b busy=%0b last=%0b want 0", out_valid, busy, out_last); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_run_done got=%0b want=0", done); end
        checks++; if (out_data !== 128'd0) begin failures++; $display("[TB] FAIL rst_run_data got=%h want=0", out_data); end
        rst = 1'b0;
        model_reset();
`ifdef KISS_STATE_READBACK_EN
        for (int i = 0; i < 4; i++) begin
            rd_lane = 2'(i);
            #1;
            checks++; if (rd_state !== m4[i]) begin failures++; $display("[TB] FAIL rst_run_seed%0d got=%h want=%h", i, rd_state, m4[i]); end
        end
`endif
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_run_late_done got=%0b want=0", done); end
        start = 1'b1; length = 16'd1;
        @(negedge clk);
        start = 1'b0;
        adv4(f);
        checks++; if (out_data !== f) begin failures++; $display("[TB] FAIL rst_run_reseeded got=%h want=%h", out_data, f); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL rst_run_done_after got=%0b want=1", done); end
    endtask

    task automatic test_lanes_1_8();
        logic [255:0] e8;
        logic [31:0]  e1;
        int runs [2] = '{3, 4};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        out_ready_x = 1'b1;
        for (int r = 0; r < 2; r++) begin
            start_x = 1'b1; length_x = 16'(runs[r]);
            @(negedge clk);
            start_x = 1'b0;
            for (int k = 0; k < runs[r]; k++) begin
                adv8(e8);
                adv1(e1);
                checks++; if (data8 !== e8 || valid8 !== 1'b1) begin failures++; $display("[TB] FAIL lanes8_r%0d_b%0d got=%h want=%h", r, k, data8, e8); end
                checks++; if (data1 !== e1 || valid1 !== 1'b1) begin failures++; $display("[TB] FAIL lanes1_r%0d_b%0d got=%h want=%h", r, k, data1, e1); end
                checks++; if (last8 !== (k == runs[r] - 1) || last1 !== (k == runs[r] - 1)) begin
                    failures++; $display("[TB] FAIL lanes_last_r%0d_b%0d got=%0b/%0b want=%0b", r, k, last8, last1, k == runs[r] - 1); end
                @(negedge clk);
            end
            checks++; if (done8 !== 1'b1 || done1 !== 1'b1 || valid8 !== 1'b0) begin
                failures++; $display("[TB] FAIL lanes_done_r%0d got done8=%0b done1=%0b valid8=%0b want 1/1/0", r, done8, done1, valid8); end
        end
        out_ready_x = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_zero_length();
        test_ignore_in_run();
        test_reset_mid_run();
        test_lanes_1_8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kiss_stream_gen.md
KISS_STREAM_GEN -- requirements
Module: kiss_stream_gen

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent KISS generators; legal range 1..8.
REQ-002 SHALL have parameter LEN_W, default 16: width of the beat-count request.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rises on clk.
REQ-004 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port seed_we, input, 1 bit: seed-word write strobe.
REQ-006 SHALL have port seed_lane, input, $clog2(LANES) bits (min 1): target lane.
REQ-007 SHALL have port seed_sel, input, 2 bits: 0=z, 1=w, 2=jsr, 3=jcong.
REQ-008 SHALL have port seed_data, input, 32 bits: value written.
REQ-009 SHALL have port start, input, 1 bit: request a run of `length` beats.
REQ-010 SHALL have port length, input, LEN_W bits: beats requested, sampled with start.
REQ-011 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at end of run.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds a beat.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-015 SHALL have port out_data, output, 32*LANES bits: lane i occupies bits [32i+31:32i].
REQ-016 SHALL have port out_last, output, 1 bit: current beat is the final beat of the run.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and RUN.
REQ-018 SHALL, per lane and per step, apply: z=36969*(z&65535)+(z>>16); w=18000*(w&65535)+(w>>16); MWC=(z<<16)+w; jsr^=jsr<<17; jsr^=jsr>>13; jsr^=jsr<<5; jcong=69069*jcong+1234567; A=(MWC^jcong)+jsr; all arithmetic is unsigned 32-bit with wrap.
REQ-019 SHALL, in IDLE, on start with length!=0: step every lane, register the A values into out_data, load remaining=length, and enter RUN; out_valid rises the next cycle.
REQ-020 SHALL, in IDLE, on start with length==0: stay in IDLE, leave state unchanged, and pulse done the next cycle.
REQ-021 SHALL, in RUN, hold out_valid=1 and keep out_data stable until out_valid&&out_ready.
REQ-022 SHALL, on acceptance with remaining>1: step all lanes, present the new beat the next cycle, and decrement remaining; back-to-back acceptance gives one beat per cycle.
REQ-023 SHALL, on acceptance with remaining==1: go to IDLE, drop out_valid, and pulse done in the same next cycle; no extra step is taken.
REQ-024 SHALL drive out_last=1 exactly when in RUN and remaining==1.
REQ-025 SHALL ignore start while in RUN.
REQ-026 SHALL apply seed_we only in IDLE and ignore it in RUN; if seed_we and start coincide in IDLE, the seed write takes effect first and the step uses the written value.
REQ-027 SHALL keep lane state persistent between runs, so consecutive runs continue the sequence.

Reset
REQ-028 SHALL, on rst: FSM=IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, remaining=0.
REQ-029 SHALL, on rst, set lane i state to z=362436069, w=521288629, jsr=123456789, jcong=380116160+i.
REQ-030 SHALL let rst mid-RUN abort the run immediately with no done pulse.

Configuration
REQ-031 SHALL, with KISS_STATE_READBACK_EN defined, add input rd_lane ($clog2(LANES) bits) and output rd_state (128 bits = {jcong,jsr,w,z} of that lane, combinational).
REQ-032 SHALL, without KISS_STATE_READBACK_EN, omit these ports; all other behaviour is identical.

Structure
REQ-033 SHALL place in the shared package: the kiss_state_t packed struct (z,w,jsr,jcong), the reset-seed constants, and the fsm enum.
REQ-034 SHALL use one sub-module, kiss_step: a combinational one-step next-state plus A, instantiated LANES times.

Verification
REQ-035 SHALL cover: lane0 seeded z=1,w=1,jsr=1,jcong=0; start length=1 -> out_data[31:0]=0x90BD9308, out_last=1, then done; readback z=0x9069, w=0x4650, jsr=0x00420231, jcong=0x0012D687.
REQ-036 SHALL cover: length=5 with out_ready held low 3 cycles at beat 2 -> beat 2 held stable, exactly 5 beats, done once.
REQ-037 SHALL cover: length=0 -> no out_valid, done pulse one cycle after start.
REQ-038 SHALL cover: seed_we and start during RUN -> both ignored, sequence matches the software model.
REQ-039 SHALL cover: rst asserted at beat 3 of 8 -> outputs at reset values next cycle, lane states equal to the reset seeds.
REQ-040 SHALL cover: LANES=1 and LANES=8 builds with runs of 3 beats + 4 beats -> matches one continuous 7-step model per lane.
